// File: rtl/instr_constraint_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_constraint_monitor_if : instruction-stream and violation-report bundle |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
interface instr_constraint_monitor_if #(
  parameter int NUM_CORES = 2,
  parameter int COUNT_W   = 16
);
  logic                      clear;
  logic [NUM_CORES-1:0]      instr_valid;
  logic [32*NUM_CORES-1:0]   instruction;
  logic [32*NUM_CORES-1:0]   rs1_value;
  logic [NUM_CORES-1:0]      stall;
  logic [NUM_CORES-1:0]      viol_flag;
  logic [4*NUM_CORES-1:0]    viol_code;
  logic                      any_viol;
  logic [COUNT_W-1:0]        viol_count;
  logic [32*NUM_CORES-1:0]   err_instr;

  modport master (
    output clear, instr_valid, instruction, rs1_value, stall,
    input  viol_flag, viol_code, any_viol, viol_count, err_instr
  );

  modport slave (
    input  clear, instr_valid, instruction, rs1_value, stall,
    output viol_flag, viol_code, any_viol, viol_count, err_instr
  );
endinterface
`default_nettype wire

// File: rtl/instr_constraint_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_constraint_monitor : per-core RISC-V instruction-stream legality      |
// | monitor with sticky flags, first-cause codes and a saturating counter.      |
// | Optional macro ERR_CAPTURE_EN: capture first offending instruction per core.|
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module instr_constraint_monitor #(
  parameter int NUM_CORES  = 2,
  parameter int MEM_LIMIT  = 1024,
  parameter int STALL_HOLD = 2,
  parameter int COUNT_W    = 16
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  instr_constraint_monitor_if.slave mon
);
  localparam logic [31:0]        c_mem_limit  = 32'(MEM_LIMIT);
  localparam logic [3:0]         c_stall_hold = 4'(STALL_HOLD);
  localparam logic [COUNT_W-1:0] c_count_max  = {COUNT_W{1'b1}};

  localparam logic [6:0] c_op_r = 7'b0110011;
  localparam logic [6:0] c_op_i = 7'b0010011;
  localparam logic [6:0] c_op_l = 7'b0000011;
  localparam logic [6:0] c_op_s = 7'b0100011;
  localparam logic [6:0] c_op_b = 7'b1100011;
  localparam logic [6:0] c_op_u = 7'b0110111;
  localparam logic [6:0] c_op_j = 7'b1101111;

  logic [NUM_CORES-1:0]      r_flag;
  logic [NUM_CORES-1:0][3:0] r_code;
  logic [COUNT_W-1:0]        r_count;
  logic [31:0]               r_hold [NUM_CORES];
  logic [3:0]                r_cnt  [NUM_CORES];

  logic [3:0]                w_code [NUM_CORES];
  logic [3:0]                w_nviol;
  logic [COUNT_W+3:0]        w_sum;
  logic [COUNT_W-1:0]        w_count_nxt;

  always_comb begin
    logic [31:0] ins;
    logic [31:0] rs1;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] ld_addr;
    logic [31:0] st_addr;
    logic [3:0]  code;
    w_nviol = 4'd0;
    for (int n = 0; n < NUM_CORES; n++) begin
      ins     = mon.instruction[32*n +: 32];
      rs1     = mon.rs1_value[32*n +: 32];
      op      = ins[6:0];
      rd      = ins[11:7];
      f3      = ins[14:12];
      ld_addr = rs1 + {{20{ins[31]}}, ins[31:20]};
      st_addr = rs1 + {{20{ins[31]}}, ins[31:25], ins[11:7]};
      code    = 4'd0;
      if (mon.instr_valid[n]) begin
        if (!(op == c_op_r || op == c_op_i || op == c_op_l || op == c_op_s ||
              op == c_op_b || op == c_op_u || op == c_op_j))
          code = 4'd1;
        else if ((op == c_op_r || op == c_op_i || op == c_op_u) && rd == 5'd0)
          code = 4'd2;
        else if (op == c_op_l && rd == 5'd0)
          code = 4'd3;
        else if (op == c_op_l && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111))
          code = 4'd4;
        else if (op == c_op_l && ld_addr >= c_mem_limit)
          code = 4'd5;
        else if (op == c_op_s && (f3[2] || f3 == 3'b011))
          code = 4'd6;
        else if (op == c_op_s && st_addr >= c_mem_limit)
          code = 4'd7;
      end
      // Stall stability is checked whether or not the channel is valid.
      if (code == 4'd0 && r_cnt[n] != 4'd0 && ins != r_hold[n])
        code = 4'd8;
      w_code[n] = code;
      w_nviol   = w_nviol + 4'(code != 4'd0);
    end
  end

  assign w_sum       = (mon.clear ? {(COUNT_W+4){1'b0}} : {4'b0, r_count})
                     + {{COUNT_W{1'b0}}, w_nviol};
  assign w_count_nxt = (w_sum > {4'b0, c_count_max}) ? c_count_max : w_sum[COUNT_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flag  <= '0;
      r_code  <= '0;
      r_count <= '0;
      for (int n = 0; n < NUM_CORES; n++) begin
        r_hold[n] <= '0;
        r_cnt[n]  <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      for (int n = 0; n < NUM_CORES; n++) begin
        if (w_code[n] != 4'd0) begin
          if (!r_flag[n] || mon.clear) begin
            r_flag[n] <= 1'b1;
            r_code[n] <= w_code[n];
          end
        end else if (mon.clear) begin
          r_flag[n] <= 1'b0;
          r_code[n] <= 4'd0;
        end
        if (mon.stall[n]) begin
          r_hold[n] <= mon.instruction[32*n +: 32];
          r_cnt[n]  <= c_stall_hold;
        end else if (r_cnt[n] != 4'd0) begin
          r_cnt[n]  <= r_cnt[n] - 4'd1;
        end
      end
    end
  end

`ifdef ERR_CAPTURE_EN
  logic [NUM_CORES-1:0][31:0] r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= '0;
    end else begin
      for (int n = 0; n < NUM_CORES; n++) begin
        if (w_code[n] != 4'd0) begin
          if (!r_flag[n] || mon.clear)
            r_err[n] <= mon.instruction[32*n +: 32];
        end else if (mon.clear) begin
          r_err[n] <= '0;
        end
      end
    end
  end

  assign mon.err_instr = r_err;
`else
  assign mon.err_instr = '0;
`endif

  assign mon.viol_flag  = r_flag;
  assign mon.viol_code  = r_code;
  assign mon.any_viol   = |r_flag;
  assign mon.viol_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_constraint_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_constraint_monitor : directed bench for instr_constraint_monitor   |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_instr_constraint_monitor;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

`ifdef ERR_CAPTURE_EN
  localparam bit c_cap = 1'b1;
`else
  localparam bit c_cap = 1'b0;
`endif

  localparam logic [31:0] c_add  = 32'h003100B3;
  localparam logic [31:0] c_add0 = 32'h00310033;
  localparam logic [31:0] c_bad  = 32'h0000007F;
  localparam logic [31:0] c_lw   = 32'h0000A283;
  localparam logic [31:0] c_sd   = 32'h0020B023;
  localparam logic [31:0] c_sw0  = 32'h0020A023;
  localparam logic [31:0] c_swm4 = 32'hFE20AE23;
  localparam logic [31:0] c_addb = 32'h002081B3;

  instr_constraint_monitor_if #(.NUM_CORES(2), .COUNT_W(16)) if0 ();
  instr_constraint_monitor_if #(.NUM_CORES(2), .COUNT_W(2))  if1 ();

  assign if1.clear       = if0.clear;
  assign if1.instr_valid = if0.instr_valid;
  assign if1.instruction = if0.instruction;
  assign if1.rs1_value   = if0.rs1_value;
  assign if1.stall       = if0.stall;

  instr_constraint_monitor #(.NUM_CORES(2), .MEM_LIMIT(1024), .STALL_HOLD(2), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .mon(if0.slave)
  );

  instr_constraint_monitor #(.NUM_CORES(2), .MEM_LIMIT(1024), .STALL_HOLD(2), .COUNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .mon(if1.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int n, input logic v, input logic [31:0] ins, input logic [31:0] rs1);
    if0.instr_valid[n]          = v;
    if0.instruction[32*n +: 32] = ins;
    if0.rs1_value[32*n +: 32]   = rs1;
  endtask

  function automatic logic [63:0] err_exp(input logic [31:0] e1, input logic [31:0] e0);
    return c_cap ? {e1, e0} : 64'h0;
  endfunction

  initial begin
    if0.clear = 1'b0;
    if0.stall = 2'b00;
    set_core(0, 1'b0, c_add, 32'h0);
    set_core(1, 1'b0, c_add, 32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flag", 64'(if0.viol_flag), 64'h0);
    chk("rst_code", 64'(if0.viol_code), 64'h0);
    chk("rst_any", 64'(if0.any_viol), 64'h0);
    chk("rst_count", 64'(if0.viol_count), 64'h0);
    chk("rst_err", 64'(if0.err_instr), 64'h0);
    reset = 1'b0;

    // Legal ADD for 10 cycles
    set_core(0, 1'b1, c_add, 32'h0);
    repeat (10) tick();
    chk("legal_flag", 64'(if0.viol_flag), 64'h0);
    chk("legal_count", 64'(if0.viol_count), 64'h0);
    chk("legal_any", 64'(if0.any_viol), 64'h0);

    // ADD x0 on core0, illegal opcode on core1
    set_core(0, 1'b1, c_add0, 32'h0);
    set_core(1, 1'b1, c_bad, 32'h0);
    tick();
    chk("dual_flag", 64'(if0.viol_flag), 64'h3);
    chk("dual_code", 64'(if0.viol_code), 64'h12);
    chk("dual_count", 64'(if0.viol_count), 64'd2);
    chk("dual_any", 64'(if0.any_viol), 64'h1);
    chk("dual_err", 64'(if0.err_instr), err_exp(c_bad, c_add0));
    chk("sat_dual_count", 64'(if1.viol_count), 64'd2);
    chk("sat_dual_code", 64'(if1.viol_code), 64'h12);

    // Later violation keeps first code but counts
    set_core(0, 1'b1, c_bad, 32'h0);
    set_core(1, 1'b0, c_add, 32'h0);
    tick();
    chk("sticky_code", 64'(if0.viol_code), 64'h12);
    chk("sticky_count", 64'(if0.viol_count), 64'd3);
    chk("sticky_err", 64'(if0.err_instr), err_exp(c_bad, c_add0));
    tick();
    chk("count4", 64'(if0.viol_count), 64'd4);
    chk("sat_count", 64'(if1.viol_count), 64'd3);
    set_core(1, 1'b1, c_bad, 32'h0);
    tick();
    chk("sat_hold", 64'(if1.viol_count), 64'd3);
    chk("count6", 64'(if0.viol_count), 64'd6);

    // Clear with no violation
    set_core(0, 1'b1, c_add, 32'h0);
    set_core(1, 1'b0, c_add, 32'h0);
    if0.clear = 1'b1;
    tick();
    if0.clear = 1'b0;
    chk("clr_flag", 64'(if0.viol_flag), 64'h0);
    chk("clr_code", 64'(if0.viol_code), 64'h0);
    chk("clr_count", 64'(if0.viol_count), 64'h0);
    chk("clr_sat_count", 64'(if1.viol_count), 64'h0);
    chk("clr_err", 64'(if0.err_instr), 64'h0);

    // Load address range
    set_core(0, 1'b1, c_lw, 32'd1020);
    tick();
    chk("lw_ok_flag", 64'(if0.viol_flag), 64'h0);
    set_core(0, 1'b1, c_lw, 32'd1024);
    tick();
    chk("lw_lim_code", 64'(if0.viol_code), 64'h05);
    chk("lw_lim_count", 64'(if0.viol_count), 64'd1);

    // Clear coincident with violations: violations win
    set_core(0, 1'b1, c_lw, 32'hFFFFFFFF);
    set_core(1, 1'b1, c_bad, 32'h0);
    if0.clear = 1'b1;
    tick();
    if0.clear = 1'b0;
    chk("clrv_flag", 64'(if0.viol_flag), 64'h3);
    chk("clrv_code", 64'(if0.viol_code), 64'h15);
    chk("clrv_count", 64'(if0.viol_count), 64'd2);
    chk("clrv_sat_count", 64'(if1.viol_count), 64'd2);
    chk("clrv_sat_flag", 64'(if1.viol_flag), 64'h3);
    chk("clrv_err", 64'(if0.err_instr), err_exp(c_bad, c_lw));

    // Store funct3 011
    set_core(0, 1'b0, c_add, 32'h0);
    set_core(1, 1'b0, c_add, 32'h0);
    if0.clear = 1'b1;
    tick();
    if0.clear = 1'b0;
    set_core(0, 1'b1, c_sd, 32'h0);
    tick();
    chk("sd_code", 64'(if0.viol_code), 64'h06);
    chk("sd_count", 64'(if0.viol_count), 64'd1);

    // Store wraparound on core1, in-range store at limit-1 on core0
    set_core(0, 1'b0, c_add, 32'h0);
    if0.clear = 1'b1;
    tick();
    if0.clear = 1'b0;
    set_core(0, 1'b1, c_sw0, 32'd1023);
    set_core(1, 1'b1, c_swm4, 32'd2);
    tick();
    chk("sw_flag", 64'(if0.viol_flag), 64'h2);
    chk("sw_code", 64'(if0.viol_code), 64'h70);
    chk("sw_count", 64'(if0.viol_count), 64'd1);

    // Stall window honoured
    set_core(0, 1'b0, c_add, 32'h0);
    set_core(1, 1'b0, c_add, 32'h0);
    if0.clear = 1'b1;
    tick();
    if0.clear = 1'b0;
    set_core(0, 1'b1, c_add, 32'h0);
    if0.stall = 2'b01;
    tick();
    if0.stall = 2'b00;
    tick();
    tick();
    set_core(0, 1'b1, c_addb, 32'h0);
    tick();
    chk("stall_ok_flag", 64'(if0.viol_flag), 64'h0);
    chk("stall_ok_count", 64'(if0.viol_count), 64'h0);

    // Stall window broken on 2nd cycle
    set_core(0, 1'b1, c_add, 32'h0);
    if0.stall = 2'b01;
    tick();
    if0.stall = 2'b00;
    tick();
    set_core(0, 1'b1, c_addb, 32'h0);
    tick();
    chk("stall_bad_flag", 64'(if0.viol_flag), 64'h1);
    chk("stall_bad_code", 64'(if0.viol_code), 64'h08);
    chk("stall_bad_err", 64'(if0.err_instr), err_exp(32'h0, c_addb));

    // Reset mid-window
    set_core(0, 1'b0, c_add, 32'h0);
    if0.clear = 1'b1;
    tick();
    if0.clear = 1'b0;
    set_core(0, 1'b1, c_add, 32'h0);
    set_core(1, 1'b1, c_bad, 32'h0);
    if0.stall = 2'b01;
    tick();
    if0.stall = 2'b00;
    chk("pre_rst_flag", 64'(if0.viol_flag), 64'h2);
    reset = 1'b1;
    #1;
    chk("mid_rst_flag", 64'(if0.viol_flag), 64'h0);
    chk("mid_rst_code", 64'(if0.viol_code), 64'h0);
    chk("mid_rst_count", 64'(if0.viol_count), 64'h0);
    chk("mid_rst_any", 64'(if0.any_viol), 64'h0);
    set_core(1, 1'b0, c_add, 32'h0);
    set_core(0, 1'b1, c_addb, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_flag", 64'(if0.viol_flag), 64'h0);
    chk("post_rst_count", 64'(if0.viol_count), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
